// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch front end.
// Handles branch redirects, including squashing of wrong-path responses.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Branch_Zero,
    input  logic [31:0] BranchesAddr,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    output logic [31:0] PCPlus4
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT} fetchStateT;

    fetchStateT  state;
    logic [31:0] pc;
    logic [31:0] fetchPc;
    logic        drop;
    logic [31:0] target;

    assign target        = BranchesAddr & ~32'd3;
    // Request is gated by reset so it drops the moment reset asserts.
    assign imem_req_valid = rst && (state == S_REQ) && !Branch_Zero;
    assign imem_req_addr  = pc;
    assign PCPlus4        = pc + 32'd4;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            fetchPc  <= RESET_PC;
            drop     <= 1'b0;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
        end else begin
            case (state)
                S_REQ: begin
                    if (Branch_Zero) begin
                        pc <= target;
                    end else if (imem_req_ready) begin
                        fetchPc <= pc;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        state <= S_REQ;
                        drop  <= 1'b0;
                        if (Branch_Zero) begin
                            pc <= target;
                        end else if (!drop) begin
                            if_instr <= imem_rsp_data;
                            if_pc    <= fetchPc;
                            if_valid <= 1'b1;
                            pc       <= fetchPc + 32'd4;
                            state    <= S_OUT;
                        end
                    end else if (Branch_Zero) begin
                        // Stale response still in flight; remember to discard it.
                        pc   <= target;
                        drop <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (Branch_Zero || if_ready) begin
                        if_valid <= 1'b0;
                        state    <= S_REQ;
                        if (Branch_Zero) pc <= target;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed and randomized checks of pc_fetch_unit against a transaction-level
// model of in-flight fetch, stale-response and held-instruction bookkeeping.
module tb_pc_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        Branch_Zero = 1'b0;
    logic [31:0] BranchesAddr = '0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready = 1'b0;
    logic [31:0] PCPlus4;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .Branch_Zero(Branch_Zero), .BranchesAddr(BranchesAddr),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .if_ready(if_ready), .PCPlus4(PCPlus4)
    );

    int nAssert = 0;
    int nFail   = 0;

    // Reference model: next PC, whether a fetch is in flight, whether that
    // fetch has been made stale by a redirect, and the instruction on offer.
    logic [31:0] mPc, mFetchPc, mInstr, mIfPc;
    bit          mOut, mStale, mHold;

    // Instruction memory responder.
    bit          memPend = 1'b0;
    logic [31:0] memAddr = '0;
    int          memCnt  = 0;
    int          rspDelay = 0;
    bit          spur = 1'b0;

    logic [31:0] reqLog[$];
    logic [31:0] delLog[$];

    function automatic logic [31:0] memWord(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        nAssert++;
        assert (got === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge with inputs already set; returns at the next negedge.
    task automatic step();
        bit          expReq, rspNow, acc;
        logic [31:0] tgt, reqAddr;
        rspNow = memPend && memCnt == 0;
        imem_rsp_valid = rspNow || spur;
        imem_rsp_data  = rspNow ? memWord(memAddr) : $urandom;
        #1;
        expReq = !mOut && !mHold && !Branch_Zero;
        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, expReq});
        if (expReq) chk("req_addr", imem_req_addr, mPc);
        chk("pcplus4", PCPlus4, mPc + 32'd4);
        chk("if_valid", {31'b0, if_valid}, {31'b0, mHold});
        if (mHold) begin
            chk("if_instr", if_instr, mInstr);
            chk("if_pc", if_pc, mIfPc);
        end
        reqAddr = imem_req_addr;
        @(posedge clk);
        tgt = BranchesAddr & ~32'd3;
        acc = expReq && imem_req_ready;
        if (mHold && (Branch_Zero || if_ready)) begin
            if (!Branch_Zero) delLog.push_back(mIfPc);
            mHold = 1'b0;
            if (Branch_Zero) mPc = tgt;
        end else if (mOut) begin
            if (imem_rsp_valid) begin
                mOut = 1'b0;
                if (Branch_Zero) begin
                    mPc = tgt; mStale = 1'b0;
                end else if (mStale) begin
                    mStale = 1'b0;
                end else begin
                    mHold = 1'b1; mIfPc = mFetchPc;
                    mInstr = memWord(mFetchPc); mPc = mFetchPc + 32'd4;
                end
            end else if (Branch_Zero) begin
                mPc = tgt; mStale = 1'b1;
            end
        end else if (!mHold) begin
            if (Branch_Zero) mPc = tgt;
            else if (acc) begin
                mOut = 1'b1; mFetchPc = mPc; reqLog.push_back(mPc);
            end
        end
        if (rspNow) memPend = 1'b0;
        else if (memPend) memCnt--;
        if (acc) begin
            memPend = 1'b1; memAddr = reqAddr; memCnt = rspDelay;
        end
        spur = 1'b0;
        @(negedge clk);
    endtask

    task automatic doReset(bit keepMem);
        rst = 1'b0; Branch_Zero = 1'b0; spur = 1'b0; imem_rsp_valid = 1'b0;
        #1;
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_pcplus4", PCPlus4, RESET_PC + 32'd4);
        mPc = RESET_PC; mOut = 1'b0; mStale = 1'b0; mHold = 1'b0;
        if (!keepMem) memPend = 1'b0;
        reqLog.delete(); delLog.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic runUntilValid(int budget);
        int n = 0;
        while (!if_valid && n < budget) begin
            step(); n++;
        end
        chk("wait_if_valid", {31'b0, if_valid}, 32'd1);
    endtask

    initial begin
        @(negedge clk);

        // Sequential fetch from reset.
        doReset(1'b0);
        imem_req_ready = 1'b1; if_ready = 1'b1; rspDelay = 0;
        repeat (9) step();
        chk("seq_req_count", reqLog.size(), 32'd3);
        chk("seq_del_count", delLog.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("seq_req_addr", (i < reqLog.size()) ? reqLog[i] : 32'hx, 32'(4 * i));
            chk("seq_del_pc", (i < delLog.size()) ? delLog[i] : 32'hx, 32'(4 * i));
        end

        // Request and output backpressure.
        doReset(1'b0);
        imem_req_ready = 1'b0;
        repeat (5) begin
            #1;
            chk("bp_req_addr", imem_req_addr, 32'h0);
            chk("bp_req_valid", {31'b0, imem_req_valid}, 32'd1);
            step();
        end
        imem_req_ready = 1'b1; if_ready = 1'b0; rspDelay = 1;
        runUntilValid(10);
        repeat (4) begin
            #1;
            chk("bp_if_instr", if_instr, 32'hDEAD_BEEF);
            chk("bp_no_req", {31'b0, imem_req_valid}, 32'd0);
            step();
        end
        if_ready = 1'b1;
        step();

        // Redirect while a fetch is outstanding.
        doReset(1'b0);
        imem_req_ready = 1'b0; Branch_Zero = 1'b1; BranchesAddr = 32'h10;
        step();
        Branch_Zero = 1'b0; imem_req_ready = 1'b1; rspDelay = 2;
        #1 chk("wait_req_addr", imem_req_addr, 32'h10);
        step();
        imem_req_ready = 1'b0; Branch_Zero = 1'b1; BranchesAddr = 32'h203;
        step();
        Branch_Zero = 1'b0;
        for (int n = 0; n < 10 && memPend; n++) begin
            #1 chk("wait_drop_valid", {31'b0, if_valid}, 32'd0);
            step();
        end
        imem_req_ready = 1'b1;
        #1;
        chk("wait_redir_addr", imem_req_addr, 32'h200);
        chk("wait_redir_valid", {31'b0, imem_req_valid}, 32'd1);
        step();

        // Redirect while an instruction is on offer.
        doReset(1'b0);
        imem_req_ready = 1'b0; Branch_Zero = 1'b1; BranchesAddr = 32'h8;
        step();
        Branch_Zero = 1'b0; imem_req_ready = 1'b1; if_ready = 1'b0; rspDelay = 0;
        runUntilValid(10);
        chk("out_if_pc", if_pc, 32'h8);
        Branch_Zero = 1'b1; BranchesAddr = 32'h40; if_ready = 1'b1;
        step();
        Branch_Zero = 1'b0;
        #1;
        chk("out_squash", {31'b0, if_valid}, 32'd0);
        chk("out_redir_addr", imem_req_addr, 32'h40);
        step();

        // PC wrap-around.
        doReset(1'b0);
        imem_req_ready = 1'b0; Branch_Zero = 1'b1; BranchesAddr = 32'hFFFF_FFFC;
        step();
        Branch_Zero = 1'b0;
        #1;
        chk("wrap_pcplus4", PCPlus4, 32'h0);
        chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        imem_req_ready = 1'b1; if_ready = 1'b1;
        runUntilValid(10);
        step();
        #1 chk("wrap_next_addr", imem_req_addr, 32'h0);

        // Reset with a fetch in flight; the late response must be ignored.
        doReset(1'b0);
        imem_req_ready = 1'b0; Branch_Zero = 1'b1; BranchesAddr = 32'h20;
        step();
        Branch_Zero = 1'b0; imem_req_ready = 1'b1; rspDelay = 3;
        step();
        imem_req_ready = 1'b0;
        step();
        doReset(1'b1);
        for (int n = 0; n < 10 && memPend; n++) begin
            #1 chk("mid_rst_if_valid", {31'b0, if_valid}, 32'd0);
            step();
        end
        imem_req_ready = 1'b1; rspDelay = 1;
        #1 chk("mid_rst_req_addr", imem_req_addr, RESET_PC);
        step();
        imem_req_ready = 1'b0;
        #1 chk("mid_rst_wait", {31'b0, if_valid}, 32'd0);
        runUntilValid(10);
        chk("mid_rst_if_pc", if_pc, RESET_PC);

        // Randomized traffic.
        doReset(1'b0);
        for (int i = 0; i < 800; i++) begin
            Branch_Zero    = ($urandom % 10) == 0;
            BranchesAddr   = $urandom;
            imem_req_ready = ($urandom % 3) != 0;
            if_ready       = ($urandom % 3) != 0;
            rspDelay       = int'($urandom % 4);
            spur           = !memPend && !mOut && (($urandom % 8) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Owns the program counter and drives instruction fetch. It issues one fetch at a time to instruction memory and presents the fetched instruction to decode.
- Publishes PCPlus4 for next-PC selection.
- Consumes the branch-resolution pair Branch_Zero/BranchesAddr to redirect the PC and squash wrong-path fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset; bits [1:0] must be 0.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- Branch_Zero  in  1  branch taken / redirect request, sampled every cycle.
- BranchesAddr  in  32  redirect target, valid when Branch_Zero=1.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch address, equals current PC.
- imem_req_ready  in  1  memory accepts the request.
- imem_rsp_valid  in  1  fetch response valid, single-cycle pulse.
- imem_rsp_data  in  32  fetched instruction word.
- if_valid  out  1  instruction available to decode.
- if_instr  out  32  instruction word.
- if_pc  out  32  address of if_instr.
- if_ready  in  1  decode accepts the instruction.
- PCPlus4  out  32  current PC + 4.

Behaviour:
- Reset (rst=0, async)
  - PC=RESET_PC; state=S_REQ; drop=0.
  - if_valid=0; if_instr=0; if_pc=0; imem_req_valid deasserts immediately.
- PCPlus4 = PC + 32'd4, combinational, modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- Redirect target = {BranchesAddr[31:2], 2'b00}; low bits are always ignored.
- State S_REQ
  - imem_req_valid = !Branch_Zero; imem_req_addr = PC.
  - Branch_Zero=1: PC <= target; stay in S_REQ; no request issued that cycle.
  - Otherwise, on imem_req_valid & imem_req_ready: fetch_pc <= PC; go to S_WAIT.
  - Without ready, valid and addr stay stable until accepted.
- State S_WAIT (exactly one request outstanding)
  - imem_req_valid = 0.
  - Branch_Zero=1 with no rsp that cycle: PC <= target; drop <= 1; stay.
  - Branch_Zero=1 in the same cycle as imem_rsp_valid: response discarded; PC <= target; drop <= 0; go to S_REQ.
  - imem_rsp_valid with drop=1: response discarded; drop <= 0; go to S_REQ; PC unchanged (already the target).
  - imem_rsp_valid with drop=0:
    - if_instr <= imem_rsp_data; if_pc <= fetch_pc; if_valid <= 1.
    - PC <= fetch_pc + 4; go to S_OUT.
  - A repeated redirect while drop=1 updates PC to the newest target and keeps drop=1.
- State S_OUT
  - if_valid=1; if_instr and if_pc held stable until the handshake.
  - Branch_Zero=1 (priority over if_ready): if_valid <= 0, squashing the instruction; PC <= target; go to S_REQ.
  - if_ready=1 otherwise: if_valid <= 0; go to S_REQ.
  - if_ready=0 otherwise: hold state.
- imem_rsp_valid outside S_WAIT is ignored. This covers a response still in flight from a request outstanding when reset hit.
- Latency
  - Request accept to if_valid: 1 cycle after the response arrives.
  - Minimum issue interval: 3 cycles per instruction (S_REQ, S_WAIT with same-cycle response, S_OUT).
- Redirect to first request at the target: the cycle after Branch_Zero if in S_REQ or S_OUT. From S_WAIT, the request goes out after the stale response is drained.

Test Plan:
- Reset/sequential fetch: hold rst=0 for 2 cycles, then release with memory ready and responding 1 cycle later.
  - Requests go to 0x0, 0x4, 0x8.
  - if_pc equals each address in turn; PCPlus4 reads 0x4 after reset.
- Backpressure
  - imem_req_ready=0 for 5 cycles: imem_req_addr stays 0x0 and valid stays high.
  - if_ready=0 for 4 cycles with if_instr=32'hDEADBEEF: output is held unchanged, and no new request is issued.
- Redirect in S_WAIT
  - Request 0x10 outstanding; Branch_Zero=1 with BranchesAddr=0x203.
  - The response for 0x10 is discarded (if_valid stays 0).
  - The next request goes to 0x200.
- Redirect in S_OUT
  - if_valid=1 for pc 0x8; Branch_Zero=1, if_ready=1, target 0x40.
  - if_valid drops the next cycle; the next request goes to 0x40.
- Wrap-around
  - Redirect to 0xFFFFFFFC; fetch completes; the next request goes to 0x00000000.
  - PCPlus4 reads 0x0 while PC=0xFFFFFFFC.
- Reset mid-operation
  - Assert rst=0 in S_WAIT (request 0x20 outstanding); imem_rsp_valid then arrives after release.
  - The response is ignored; the first request goes to RESET_PC; if_valid stays 0 until that fetch returns.
